// File: rtl/wave_pkg.sv
// Shared types and default geometry for the wave copy sequencer.
package wave_pkg;
  localparam int DEF_SAMPLE_WIDTH    = 16;
  localparam int DEF_WW_WIDTH        = 18;
  localparam int DEF_MMEM_ADDR_WIDTH = 18;
  localparam int DEF_MMEM_DEPTH      = 2**18;
  localparam int DEF_BRAM_DEPTH      = 4096;
  localparam int DEF_NUM_TARGETS     = 6;
  localparam int DEF_READ_LATENCY    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wave_state_e;
endpackage

// File: rtl/wave_copy_sequencer_if.sv
// Request, main-memory read and destination write signals of the sequencer.
interface wave_copy_sequencer_if
  import wave_pkg::*;
#(
  parameter int SAMPLE_WIDTH    = DEF_SAMPLE_WIDTH,
  parameter int WW_WIDTH        = DEF_WW_WIDTH,
  parameter int MMEM_ADDR_WIDTH = DEF_MMEM_ADDR_WIDTH,
  parameter int NUM_TARGETS     = DEF_NUM_TARGETS
) ();
  logic                       start_in;
  logic [MMEM_ADDR_WIDTH-1:0] offset_in;
  logic [WW_WIDTH-1:0]        width_in;
  logic [NUM_TARGETS-1:0]     target_mask_in;
  logic [MMEM_ADDR_WIDTH-1:0] mmem_addr_out;
  logic                       mmem_en_out;
  logic [SAMPLE_WIDTH-1:0]    mmem_data_in;
  logic [WW_WIDTH-1:0]        wr_addr_out;
  logic [SAMPLE_WIDTH-1:0]    wr_data_out;
  logic [NUM_TARGETS-1:0]     wr_en_out;
  logic                       busy_out;
  logic                       done_out;

  modport master (
    input  start_in, offset_in, width_in, target_mask_in, mmem_data_in,
    output mmem_addr_out, mmem_en_out, wr_addr_out, wr_data_out, wr_en_out,
           busy_out, done_out
  );

  modport slave (
    output start_in, offset_in, width_in, target_mask_in, mmem_data_in,
    input  mmem_addr_out, mmem_en_out, wr_addr_out, wr_data_out, wr_en_out,
           busy_out, done_out
  );
endinterface

// File: rtl/valid_delay_line.sv
// Valid + payload shift register matching the main-memory read latency.
module valid_delay_line #(
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 18
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 vld_in,
  input  logic [PAYLOAD_W-1:0] data_in,
  output logic                 vld_out,
  output logic [PAYLOAD_W-1:0] data_out,
  output logic                 in_flight_out
);
  logic [DEPTH:1]                vld_q;
  logic [DEPTH:1][PAYLOAD_W-1:0] data_q;
  logic [DEPTH:0]                vld_pipe;
  logic [DEPTH:0][PAYLOAD_W-1:0] data_pipe;

  assign vld_pipe  = {vld_q, vld_in};
  assign data_pipe = {data_q, data_in};

  // Advance every stage by one each cycle; reset empties the line.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_pipe[DEPTH-1:0];
      data_q <= data_pipe[DEPTH-1:0];
    end
  end

  assign vld_out  = vld_pipe[DEPTH];
  assign data_out = data_pipe[DEPTH];
  // Anything still to emerge after the current output stage.
  assign in_flight_out = |vld_pipe[DEPTH-1:0];
endmodule

// File: rtl/wave_copy_sequencer.sv
// Copies a window of main memory into a set of destination BRAMs.
module wave_copy_sequencer
  import wave_pkg::*;
#(
  parameter int SAMPLE_WIDTH    = DEF_SAMPLE_WIDTH,
  parameter int WW_WIDTH        = DEF_WW_WIDTH,
  parameter int MMEM_ADDR_WIDTH = DEF_MMEM_ADDR_WIDTH,
  parameter int MMEM_DEPTH      = DEF_MMEM_DEPTH,
  parameter int BRAM_DEPTH      = DEF_BRAM_DEPTH,
  parameter int NUM_TARGETS     = DEF_NUM_TARGETS,
  parameter int READ_LATENCY    = DEF_READ_LATENCY
) (
  input logic                  clk_in,
  input logic                  rst_n_in,
  wave_copy_sequencer_if.master bus
);
  localparam logic [WW_WIDTH-1:0]        BRAM_MAX  = WW_WIDTH'(BRAM_DEPTH);
  localparam logic [MMEM_ADDR_WIDTH-1:0] ADDR_LAST = MMEM_ADDR_WIDTH'(MMEM_DEPTH - 1);

  wave_state_e state, state_nxt;

  logic [MMEM_ADDR_WIDTH-1:0] rd_addr, pend_off, req_off;
  logic [WW_WIDTH-1:0]        k_cnt, k_last, pend_w, req_w, req_eff;
  logic [NUM_TARGETS-1:0]     cur_mask, pend_mask, req_mask;
  logic                       pend_vld, use_pend, accept, req_zero, issue;
  logic                       dl_vld, dl_in_flight;
  logic [WW_WIDTH-1:0]        dl_k;
  logic [SAMPLE_WIDTH-1:0]    rd_data;

  assign rd_data = bus.mmem_data_in;
  assign issue   = (state == ST_ISSUE);

  // A fresh start_in in DONE overrides the pending request (last one wins).
  assign use_pend = (state == ST_DONE) && !bus.start_in;
  assign req_off  = use_pend ? pend_off  : bus.offset_in;
  assign req_w    = use_pend ? pend_w    : bus.width_in;
  assign req_mask = use_pend ? pend_mask : bus.target_mask_in;
  assign req_eff  = (req_w > BRAM_MAX) ? BRAM_MAX : req_w;
  assign req_zero = (req_eff == '0);
  assign accept   = bus.start_in ? (state == ST_IDLE || state == ST_DONE)
                                 : (state == ST_DONE && pend_vld);

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic; a zero-width request goes straight to DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = req_zero ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (k_cnt == k_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!dl_in_flight) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = accept ? (req_zero ? ST_DONE : ST_ISSUE) : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Copy context, read address walk and the single-entry pending request.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_addr   <= '0;
      k_cnt     <= '0;
      k_last    <= '0;
      cur_mask  <= '0;
      pend_vld  <= 1'b0;
      pend_off  <= '0;
      pend_w    <= '0;
      pend_mask <= '0;
    end else begin
      if (accept) begin
        rd_addr  <= req_off;
        k_cnt    <= '0;
        k_last   <= req_eff - WW_WIDTH'(1);
        cur_mask <= req_mask;
        pend_vld <= 1'b0;
      end else if (issue) begin
        rd_addr <= (rd_addr == ADDR_LAST) ? '0 : rd_addr + MMEM_ADDR_WIDTH'(1);
        k_cnt   <= k_cnt + WW_WIDTH'(1);
      end
      if (bus.start_in && (state == ST_ISSUE || state == ST_DRAIN)) begin
        pend_vld  <= 1'b1;
        pend_off  <= bus.offset_in;
        pend_w    <= bus.width_in;
        pend_mask <= bus.target_mask_in;
      end
    end
  end

  valid_delay_line #(
    .DEPTH     (READ_LATENCY),
    .PAYLOAD_W (WW_WIDTH)
  ) u_dly (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .vld_in        (issue),
    .data_in       (k_cnt),
    .vld_out       (dl_vld),
    .data_out      (dl_k),
    .in_flight_out (dl_in_flight)
  );

  // Outputs: reads from state, writes from the emerging pipeline slot.
  always_comb begin
    bus.mmem_en_out   = issue;
    bus.mmem_addr_out = issue ? rd_addr : '0;
    bus.wr_en_out     = dl_vld ? cur_mask : '0;
    bus.wr_addr_out   = dl_vld ? dl_k : '0;
    bus.wr_data_out   = dl_vld ? rd_data : '0;
    bus.done_out      = (state == ST_DONE);
    bus.busy_out      = (state != ST_IDLE) || pend_vld;
  end
endmodule

// File: tb/tb_wave_copy_sequencer.sv
// Directed bench for wave_copy_sequencer with a 2-cycle memory model.
module tb_wave_copy_sequencer;
  localparam int MD = 2**18;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wave_copy_sequencer_if bus ();

  wave_copy_sequencer dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.master)
  );

  int n_vec, n_err;

  function automatic logic [15:0] mem_f(input logic [17:0] a);
    return a[15:0] ^ 16'h5A3C ^ {14'd0, a[17:16]};
  endfunction

  function automatic logic [17:0] addr_exp(input logic [17:0] off, input int k);
    return 18'((int'(off) + k) % MD);
  endfunction

  // Main memory: data for an address appears two cycles after it is presented.
  logic [15:0] p1, d2;
  always @(posedge clk) begin
    p1 <= mem_f(bus.mmem_addr_out);
    d2 <= p1;
  end
  assign bus.mmem_data_in = d2;

  function automatic int outs_nz();
    return int'(bus.mmem_en_out | (|bus.mmem_addr_out) | (|bus.wr_en_out) |
                (|bus.wr_addr_out) | (|bus.wr_data_out) | bus.busy_out | bus.done_out);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue one copy from idle and watch it until done_out (bounded).
  task automatic run_copy(input logic [17:0] off, input logic [17:0] w, input logic [5:0] m,
                          output int nr, output int nw, output int done_c,
                          output int frd, output int fwr, output int bad);
    nr = 0; nw = 0; done_c = -1; frd = -1; fwr = -1; bad = 0;
    @(negedge clk);
    bus.start_in = 1'b1; bus.offset_in = off; bus.width_in = w; bus.target_mask_in = m;
    for (int c = 1; c <= 6000; c++) begin
      @(negedge clk);
      bus.start_in = 1'b0;
      if (bus.mmem_en_out) begin
        if (frd < 0) frd = c;
        if (bus.mmem_addr_out !== addr_exp(off, nr)) bad++;
        nr++;
      end
      if (bus.wr_en_out != '0) begin
        if (fwr < 0) fwr = c;
        if (bus.wr_en_out !== m || bus.wr_addr_out !== 18'(nw) ||
            bus.wr_data_out !== mem_f(addr_exp(off, nw))) bad++;
        nw++;
      end
      if (!bus.busy_out) bad++;
      if (bus.done_out) begin
        done_c = c;
        break;
      end
    end
    @(negedge clk);
    if (bus.busy_out || bus.done_out) bad++;
  endtask

  typedef struct {
    logic [17:0] off;
    logic [17:0] w;
    logic [5:0]  m;
    int nr, nw, done_c, frd, fwr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int nr, nw, dc, frd, fwr, bad;
    int dn, d1c, d2c, w4, wbad, busy_lo, rd_bad, cnt;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    bus.start_in = 1'b0; bus.offset_in = '0; bus.width_in = '0; bus.target_mask_in = '0;

    //              off         w        mask        nr    nw    done  frd fwr
    tbl[0] = '{18'd100,    18'd8,    6'b000001,   8,    8,    11,   1,  3};
    tbl[1] = '{18'(MD-3),  18'd6,    6'b100000,   6,    6,    9,    1,  3};
    tbl[2] = '{18'd0,      18'd0,    6'b000001,   0,    0,    1,   -1, -1};
    tbl[3] = '{18'd50,     18'd5000, 6'b111111,   4096, 4096, 4099, 1,  3};
    tbl[4] = '{18'd10,     18'd3,    6'b000000,   3,    0,    6,    1, -1};
    tbl[5] = '{18'd400,    18'd1,    6'b010101,   1,    1,    4,    1,  3};

    repeat (3) @(negedge clk);
    check("reset_outs", outs_nz(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs", outs_nz(), 0);

    for (int i = 0; i < 6; i++) begin
      run_copy(tbl[i].off, tbl[i].w, tbl[i].m, nr, nw, dc, frd, fwr, bad);
      check($sformatf("v%0d_reads", i),    nr,  tbl[i].nr);
      check($sformatf("v%0d_writes", i),   nw,  tbl[i].nw);
      check($sformatf("v%0d_done_cyc", i), dc,  tbl[i].done_c);
      check($sformatf("v%0d_first_rd", i), frd, tbl[i].frd);
      check($sformatf("v%0d_first_wr", i), fwr, tbl[i].fwr);
      check($sformatf("v%0d_bad", i),      bad, 0);
    end

    // Two requests while busy: only the later (width 3) one runs afterwards.
    dn = 0; d1c = -1; d2c = -1; nw = 0; w4 = 0; wbad = 0; busy_lo = 0; rd_bad = 0;
    @(negedge clk);
    bus.start_in = 1'b1; bus.offset_in = 18'd0; bus.width_in = 18'd10; bus.target_mask_in = 6'b000001;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c <= 19 && !bus.busy_out) busy_lo++;
      if (c >= 20 && bus.busy_out) busy_lo++;
      if (bus.done_out) begin
        dn++;
        if (dn == 1) d1c = c; else d2c = c;
      end
      if (bus.wr_en_out != '0) begin
        nw++;
        if (bus.wr_en_out == 6'b000100) begin
          if (bus.wr_addr_out !== 18'(w4) || bus.wr_data_out !== mem_f(addr_exp(18'd300, w4))) wbad++;
          w4++;
        end
      end
      if (bus.mmem_en_out && bus.mmem_addr_out >= 18'd200 && bus.mmem_addr_out < 18'd204) rd_bad++;
      bus.start_in       = (c == 3) || (c == 5);
      bus.offset_in      = (c == 3) ? 18'd200 : 18'd300;
      bus.width_in       = (c == 3) ? 18'd4 : 18'd3;
      bus.target_mask_in = (c == 3) ? 6'b000010 : 6'b000100;
    end
    check("pend_done_cnt", dn, 2);
    check("pend_done1_cyc", d1c, 13);
    check("pend_done2_cyc", d2c, 19);
    check("pend_writes", nw, 13);
    check("pend_w3_writes", w4, 3);
    check("pend_w3_bad", wbad, 0);
    check("pend_busy", busy_lo, 0);
    check("pend_w4_reads", rd_bad, 0);

    // Reset in the middle of ISSUE.
    @(negedge clk);
    bus.start_in = 1'b1; bus.offset_in = 18'd0; bus.width_in = 18'd20; bus.target_mask_in = 6'b111111;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.start_in = 1'b0;
    end
    check("pre_rst_wr_en", int'(bus.wr_en_out), 63);
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", outs_nz(), 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt += outs_nz();
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      cnt += outs_nz();
    end
    check("post_rst_quiet", cnt, 0);
    run_copy(18'd7, 18'd4, 6'b000011, nr, nw, dc, frd, fwr, bad);
    check("after_rst_reads", nr, 4);
    check("after_rst_writes", nw, 4);
    check("after_rst_done_cyc", dc, 7);
    check("after_rst_bad", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
